// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: per-GPR in-flight writer counts and decode interlock.
// Optional SB_BYPASS_EN: forwarding present, stall only on loads still in or before EX.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ds_valid,
    input  logic [4:0] ds_rs,
    input  logic [4:0] ds_rt,
    input  logic       ds_rs_used,
    input  logic       ds_rt_used,
    input  logic       ds_gr_we,
    input  logic [4:0] ds_dest,
    input  logic       ds_load,
    input  logic       es_allowin,
    input  logic       es_to_ms_fire,
    input  logic [4:0] es_dest,
    input  logic       es_load,
    input  logic       ws_we,
    input  logic [4:0] ws_waddr,
    input  logic       flush,
    output logic       ds_ready_go,
    output logic       rs_busy,
    output logic       rt_busy,
    output logic       sb_error
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             sb_error_q;
    logic             sb_error_d;

    logic dest_nz;
    logic retire;
    logic retire_dest;
    logic sat;
    logic src_stall;
    logic issue;

    assign dest_nz     = ds_dest != 5'd0;
    assign retire      = ws_we & (ws_waddr != 5'd0);
    assign retire_dest = retire & (ws_waddr == ds_dest);

    assign rs_busy = ds_rs_used & (ds_rs != 5'd0) & (cnt_q[ds_rs] != '0);
    assign rt_busy = ds_rt_used & (ds_rt != 5'd0) & (cnt_q[ds_rt] != '0);

    // A retire of the destination this cycle frees a slot, so it lifts saturation.
    assign sat = ds_gr_we & dest_nz & (cnt_q[ds_dest] == CMAX) & ~retire_dest;

    assign ds_ready_go = ~ds_valid | ~(sat | src_stall);
    assign issue       = ds_valid & ds_ready_go & es_allowin & ds_gr_we & dest_nz;
    assign sb_error    = sb_error_q;

`ifdef SB_BYPASS_EN
    logic [NREG-1:0] lpend_q;
    logic [NREG-1:0] lpend_d;

    assign src_stall = (rs_busy & lpend_q[ds_rs]) | (rt_busy & lpend_q[ds_rt]);

    always_comb begin
        lpend_d = lpend_q;
        if (flush) begin
            lpend_d = '0;
        end else begin
            if (es_to_ms_fire & es_load)
                lpend_d[es_dest] = 1'b0;
            if (issue & ds_load)
                lpend_d[ds_dest] = 1'b1;
        end
        lpend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            lpend_q <= '0;
        else
            lpend_q <= lpend_d;
    end
`else
    logic unused_lp;

    assign src_stall = rs_busy | rt_busy;
    assign unused_lp = ^{ds_load, es_to_ms_fire, es_dest, es_load};
`endif

    always_comb begin
        cnt_d      = cnt_q;
        sb_error_d = sb_error_q;
        if (flush) begin
            for (int i = 0; i < NREG; i++)
                cnt_d[i] = '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (retire && ws_waddr == 5'(i) && cnt_q[i] == '0)
                    sb_error_d = 1'b1;
                if (issue && ds_dest == 5'(i)) begin
                    if (!(retire && ws_waddr == 5'(i)))
                        cnt_d[i] = cnt_q[i] + 1'b1;
                end else if (retire && ws_waddr == 5'(i)) begin
                    if (cnt_q[i] != '0)
                        cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++)
                cnt_q[i] <= '0;
            sb_error_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sb_error_q <= sb_error_d;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed-vector bench for reg_scoreboard.
// Expected values adapt to SB_BYPASS_EN when defined.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ds_valid, ds_rs_used, ds_rt_used, ds_gr_we, ds_load;
    logic [4:0] ds_rs, ds_rt, ds_dest;
    logic       es_allowin, es_to_ms_fire, es_load;
    logic [4:0] es_dest;
    logic       ws_we;
    logic [4:0] ws_waddr;
    logic       flush;
    logic       ds_ready_go, rs_busy, rt_busy, sb_error;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .resetn(resetn),
        .ds_valid(ds_valid), .ds_rs(ds_rs), .ds_rt(ds_rt),
        .ds_rs_used(ds_rs_used), .ds_rt_used(ds_rt_used),
        .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_load(ds_load),
        .es_allowin(es_allowin), .es_to_ms_fire(es_to_ms_fire),
        .es_dest(es_dest), .es_load(es_load),
        .ws_we(ws_we), .ws_waddr(ws_waddr), .flush(flush),
        .ds_ready_go(ds_ready_go), .rs_busy(rs_busy),
        .rt_busy(rt_busy), .sb_error(sb_error)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ds_valid = 0; ds_rs_used = 0; ds_rt_used = 0; ds_gr_we = 0;
        ds_load = 0; ds_rs = 0; ds_rt = 0; ds_dest = 0;
        es_allowin = 1; es_to_ms_fire = 0; es_load = 0; es_dest = 0;
        ws_we = 0; ws_waddr = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] d, input logic ld);
        idle();
        ds_valid = 1; ds_gr_we = 1; ds_dest = d; ds_load = ld;
    endtask

    task automatic rd_rs(input logic [4:0] r);
        idle();
        ds_valid = 1; ds_rs_used = 1; ds_rs = r;
    endtask

    task automatic rd_rt(input logic [4:0] r);
        idle();
        ds_valid = 1; ds_rt_used = 1; ds_rt = r;
    endtask

    task automatic wb(input logic [4:0] r);
        idle();
        ws_we = 1; ws_waddr = r;
    endtask

    logic bp;

    initial begin
`ifdef SB_BYPASS_EN
        bp = 1'b1;
`else
        bp = 1'b0;
`endif
        idle();
        resetn = 0;
        #1;
        chk("rst_rs_busy", rs_busy, 0);
        chk("rst_sb_error", sb_error, 0);
        #20;
        resetn = 1;
        tick();

        // 1: async reset with cnt[5]=2
        wr(5, 0); #1; chk("t1_go0", ds_ready_go, 1); tick();
        wr(5, 0); #1; chk("t1_go1", ds_ready_go, 1); tick();
        rd_rs(5); #1; chk("t1_busy", rs_busy, 1);
        #2; resetn = 0; #1;
        chk("t1_rst_busy", rs_busy, 0);
        chk("t1_rst_err", sb_error, 0);
        tick(); resetn = 1; tick();
        rd_rs(5); #1; chk("t1_after_busy", rs_busy, 0);
        chk("t1_after_go", ds_ready_go, 1);

        // 2: addu r5 then read r5
        wr(5, 0); tick();
        rd_rs(5); #1;
        chk("t2_busy", rs_busy, 1);
        chk("t2_go", ds_ready_go, bp);
        ds_valid = 0; #1;
        chk("t2_novalid_go", ds_ready_go, 1);
        ds_valid = 1; tick();
        chk("t2_go_hold", ds_ready_go, bp);
        ws_we = 1; ws_waddr = 5; #1;
        chk("t2_go_wbcyc", ds_ready_go, bp);
        tick();
        ws_we = 0; #1;
        chk("t2_go_after", ds_ready_go, 1);
        chk("t2_busy_after", rs_busy, 0);

        // 3: lw r8 then read rt=8
        wr(8, 1); tick();
        rd_rt(8); #1;
        chk("t3_busy", rt_busy, 1);
        chk("t3_go", ds_ready_go, 0);
        es_to_ms_fire = 1; es_dest = 8; es_load = 1; #1;
        chk("t3_go_fire", ds_ready_go, 0);
        tick();
        es_to_ms_fire = 0; es_load = 0; #1;
        chk("t3_go_postfire", ds_ready_go, bp);
        ws_we = 1; ws_waddr = 8; tick();
        ws_we = 0; #1;
        chk("t3_go_wb", ds_ready_go, 1);

        // 4: saturation on r2
        for (int i = 0; i < 3; i++) begin
            wr(2, 0); #1; chk("t4_go_fill", ds_ready_go, 1); tick();
        end
        wr(2, 0); #1;
        chk("t4_sat", ds_ready_go, 0);
        ws_we = 1; ws_waddr = 2; #1;
        chk("t4_sat_lift", ds_ready_go, 1);
        tick();
        wr(2, 0); #1;
        chk("t4_still_sat", ds_ready_go, 0);
        wb(2); tick(); wb(2); tick();
        rd_rs(2); #1; chk("t4_cnt1", rs_busy, 1);
        wb(2); tick();
        rd_rs(2); #1; chk("t4_cnt0", rs_busy, 0);
        chk("t4_no_err", sb_error, 0);

        // 5: same-cycle issue+retire, then underflow
        wr(9, 0); tick();
        wr(9, 0); ws_we = 1; ws_waddr = 9; tick();
        rd_rs(9); #1; chk("t5_cnt1", rs_busy, 1);
        wb(9); tick();
        rd_rs(9); #1; chk("t5_cnt0", rs_busy, 0);
        chk("t5_no_err", sb_error, 0);
        wb(4); tick();
        idle(); #1; chk("t5_err", sb_error, 1);
        tick(); tick();
        chk("t5_err_sticky", sb_error, 1);

        // 6: flush with pending load writers on r3
        wr(3, 1); tick(); wr(3, 1); tick();
        rd_rs(3); #1; chk("t6_busy_pre", rs_busy, 1);
        wr(3, 1); flush = 1; tick();
        rd_rs(3); #1;
        chk("t6_busy_post", rs_busy, 0);
        chk("t6_go_post", ds_ready_go, 1);
        chk("t6_err_kept", sb_error, 1);
        wr(3, 0); tick();
        rd_rs(3); #1;
        chk("t6_lpend_clr", ds_ready_go, bp);
        wb(3); tick();

        // r0 is never tracked
        wr(0, 0); tick();
        rd_rs(0); ds_rt_used = 1; ds_rt = 0; #1;
        chk("r0_rs_busy", rs_busy, 0);
        chk("r0_rt_busy", rt_busy, 0);
        chk("r0_go", ds_ready_go, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
